// File: rtl/regfile_rd_pipe_if.sv
// Bundle of the write port and the handshaked dual read port of regfile_rd_pipe.
// The master drives writes and requests; the slave (the register file) returns data.
interface regfile_rd_pipe_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic             req_valid;
    logic             req_ready;
    logic [AW-1:0]    ra1;
    logic [AW-1:0]    ra2;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;

    modport master (
        output we, wa, wd, req_valid, ra1, ra2, rsp_ready,
        input  req_ready, rsp_valid, rd1, rd2
    );

    modport slave (
        input  we, wa, wd, req_valid, ra1, ra2, rsp_ready,
        output req_ready, rsp_valid, rd1, rd2
    );
endinterface

// File: rtl/regfile_rd_pipe.sv
// Register file with one write port and a handshaked dual read port whose results are
// captured into a single-entry response buffer with write-first bypass.
module regfile_rd_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input logic              Clk,
    input logic              Clrn,
    regfile_rd_pipe_if.slave bus
);
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic             rsp_valid_q;
    logic             rsp_valid_d;
    logic [WIDTH-1:0] rd1_q;
    logic [WIDTH-1:0] rd1_d;
    logic [WIDTH-1:0] rd2_q;
    logic [WIDTH-1:0] rd2_d;
    logic             wr_en;
    logic             acc;

    function automatic logic in_range(input logic [AW-1:0] addr);
        return (int'(addr) < DEPTH);
    endfunction

    // Register 0 and addresses beyond DEPTH have no storage behind them.
    function automatic logic [WIDTH-1:0] read_word(input logic [AW-1:0] addr);
        if (addr == '0 || !in_range(addr)) begin
            return '0;
        end
        return regs_q[addr];
    endfunction

    assign wr_en         = bus.we && (bus.wa != '0) && in_range(bus.wa);
    assign bus.req_ready = !rsp_valid_q || bus.rsp_ready;
    assign acc           = bus.req_valid && bus.req_ready;

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[bus.wa] <= bus.wd;
        end
    end

    // The buffer is a snapshot: it only changes on an accepted request, so writes
    // landing during a stall are seen by the next request, not the held one.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rd1_d       = rd1_q;
        rd2_d       = rd2_q;
        if (acc) begin
            rsp_valid_d = 1'b1;
            rd1_d       = (wr_en && bus.wa == bus.ra1) ? bus.wd : read_word(bus.ra1);
            rd2_d       = (wr_en && bus.wa == bus.ra2) ? bus.wd : read_word(bus.ra2);
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            rsp_valid_q <= 1'b0;
            rd1_q       <= '0;
            rd2_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rd1       = rd1_q;
    assign bus.rd2       = rd2_q;
endmodule

// File: tb/tb_regfile_rd_pipe.sv
// Directed and randomized bench for regfile_rd_pipe.
module tb_regfile_rd_pipe;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic Clk = 1'b0;
    logic Clrn;
    int   n_tests = 0;
    int   n_fail  = 0;

    regfile_rd_pipe_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    regfile_rd_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .Clk  (Clk),
        .Clrn (Clrn),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] ev(input int i);
        return (i == 0) ? 32'h0 : (32'hA000_0000 | 32'(i));
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        bus.we        = 1'b0;
        bus.wa        = '0;
        bus.wd        = '0;
        bus.req_valid = 1'b0;
        bus.ra1       = '0;
        bus.ra2       = '0;
        bus.rsp_ready = 1'b1;
    endtask

    task automatic test_reset();
        logic [64:0] exp;
        Clrn = 1'b0;
        idle();
        repeat (2) @(posedge Clk);
        #1;
        exp = {1'b1 ^ 1'b1, 64'h0};
        n_tests++;
        if ({bus.rsp_valid, bus.rd1, bus.rd2} !== exp) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", {bus.rsp_valid, bus.rd1, bus.rd2}, exp);
        end
        n_tests++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_req_ready: got %b want 1", bus.req_ready);
        end
        @(negedge Clk);
        Clrn = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        idle();
        bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'hDEADBEEF;
        tick();
        bus.we = 1'b0;
        bus.req_valid = 1'b1; bus.ra1 = 5'd5; bus.ra2 = 5'd0;
        #1;
        n_tests++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_rd_req_ready: got %b want 1", bus.req_ready);
        end
        tick();
        bus.req_valid = 1'b0;
        n_tests++;
        if ({bus.rsp_valid, bus.rd1, bus.rd2} !== {1'b1, 32'hDEADBEEF, 32'h0}) begin
            n_fail++;
            $display("FAIL wr_rd_resp: got %h want %h", {bus.rsp_valid, bus.rd1, bus.rd2},
                     {1'b1, 32'hDEADBEEF, 32'h0});
        end
    endtask

    task automatic test_bypass();
        idle();
        bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'h1234;
        bus.req_valid = 1'b1; bus.ra1 = 5'd7; bus.ra2 = 5'd7;
        tick();
        n_tests++;
        if ({bus.rsp_valid, bus.rd1, bus.rd2} !== {1'b1, 32'h1234, 32'h1234}) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: got %h want %h", {bus.rsp_valid, bus.rd1, bus.rd2},
                     {1'b1, 32'h1234, 32'h1234});
        end
        bus.wa = 5'd0; bus.wd = 32'hFFFF; bus.ra1 = 5'd0; bus.ra2 = 5'd7;
        tick();
        n_tests++;
        if ({bus.rsp_valid, bus.rd1, bus.rd2} !== {1'b1, 32'h0, 32'h1234}) begin
            n_fail++;
            $display("FAIL bypass_reg0: got %h want %h", {bus.rsp_valid, bus.rd1, bus.rd2},
                     {1'b1, 32'h0, 32'h1234});
        end
        bus.we = 1'b0; bus.ra2 = 5'd0;
        tick();
        n_tests++;
        if ({bus.rsp_valid, bus.rd1, bus.rd2} !== {1'b1, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL reg0_after_write: got %h want %h", {bus.rsp_valid, bus.rd1, bus.rd2},
                     {1'b1, 32'h0, 32'h0});
        end
        idle();
    endtask

    task automatic test_backpressure();
        idle();
        tick();
        bus.req_valid = 1'b1; bus.ra1 = 5'd5; bus.ra2 = 5'd7; bus.rsp_ready = 1'b0;
        tick();
        n_tests++;
        if ({bus.rsp_valid, bus.rd1, bus.rd2} !== {1'b1, 32'hDEADBEEF, 32'h1234}) begin
            n_fail++;
            $display("FAIL bp_first: got %h want %h", {bus.rsp_valid, bus.rd1, bus.rd2},
                     {1'b1, 32'hDEADBEEF, 32'h1234});
        end
        bus.ra1 = 5'd5; bus.ra2 = 5'd3;
        bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'h0BADF00D;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++;
            if (bus.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_req_ready[%0d]: got %b want 0", c, bus.req_ready);
            end
            tick();
            bus.we = 1'b0;
            n_tests++;
            if ({bus.rsp_valid, bus.rd1, bus.rd2} !== {1'b1, 32'hDEADBEEF, 32'h1234}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got %h want %h", c, {bus.rsp_valid, bus.rd1, bus.rd2},
                         {1'b1, 32'hDEADBEEF, 32'h1234});
            end
        end
        bus.rsp_ready = 1'b1;
        #1;
        n_tests++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b want 1", bus.req_ready);
        end
        tick();
        bus.req_valid = 1'b0;
        n_tests++;
        if ({bus.rsp_valid, bus.rd1, bus.rd2} !== {1'b1, 32'h0BADF00D, 32'h0}) begin
            n_fail++;
            $display("FAIL bp_next_resp: got %h want %h", {bus.rsp_valid, bus.rd1, bus.rd2},
                     {1'b1, 32'h0BADF00D, 32'h0});
        end
        idle();
    endtask

    task automatic test_streaming();
        idle();
        for (int i = 1; i < 16; i++) begin
            bus.we = 1'b1; bus.wa = AW'(i); bus.wd = ev(i);
            tick();
        end
        bus.we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.req_valid = 1'b1; bus.ra1 = AW'(i); bus.ra2 = AW'(15 - i);
            #1;
            n_tests++;
            if (bus.req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_ready[%0d]: got %b want 1", i, bus.req_ready);
            end
            tick();
            n_tests++;
            if ({bus.rsp_valid, bus.rd1, bus.rd2} !== {1'b1, ev(i), ev(15 - i)}) begin
                n_fail++;
                $display("FAIL stream_resp[%0d]: got %h want %h", i, {bus.rsp_valid, bus.rd1, bus.rd2},
                         {1'b1, ev(i), ev(15 - i)});
            end
        end
        bus.req_valid = 1'b0;
        tick();
        n_tests++;
        if ({bus.rsp_valid, bus.rd1, bus.rd2} !== {1'b0, ev(15), ev(0)}) begin
            n_fail++;
            $display("FAIL stream_drain_hold: got %h want %h", {bus.rsp_valid, bus.rd1, bus.rd2},
                     {1'b0, ev(15), ev(0)});
        end
    endtask

    task automatic test_random();
        logic [31:0] m_regs [32];
        logic        m_valid;
        logic        m_ready;
        logic        m_acc;
        logic        pending;
        logic [31:0] m_rd1;
        logic [31:0] m_rd2;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = (i >= 1 && i < 16) ? ev(i) : 32'h0;
        end
        m_valid = 1'b0; m_rd1 = ev(15); m_rd2 = 32'h0; pending = 1'b0;
        idle();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            bus.we = 1'($urandom % 2);
            bus.wa = AW'($urandom % 32);
            bus.wd = $urandom;
            if (!pending) begin
                bus.req_valid = ($urandom % 4) != 0;
                bus.ra1 = (($urandom % 4) == 0) ? bus.wa : AW'($urandom % 32);
                bus.ra2 = (($urandom % 4) == 0) ? bus.wa : AW'($urandom % 32);
            end
            bus.rsp_ready = ($urandom % 3) != 0;
            #1;
            m_ready = !m_valid || bus.rsp_ready;
            n_tests++;
            if (bus.req_ready !== m_ready) begin
                n_fail++;
                $display("FAIL rand_req_ready[%0d]: got %b want %b", cyc, bus.req_ready, m_ready);
            end
            m_acc = bus.req_valid && m_ready;
            if (m_acc) begin
                m_rd1 = (bus.we && bus.wa != 0 && bus.wa == bus.ra1) ? bus.wd : m_regs[bus.ra1];
                m_rd2 = (bus.we && bus.wa != 0 && bus.wa == bus.ra2) ? bus.wd : m_regs[bus.ra2];
                m_valid = 1'b1;
            end else if (bus.rsp_ready) begin
                m_valid = 1'b0;
            end
            if (bus.we && bus.wa != 0) m_regs[bus.wa] = bus.wd;
            pending = bus.req_valid && !m_acc;
            tick();
            n_tests++;
            if ({bus.rsp_valid, bus.rd1, bus.rd2} !== {m_valid, m_rd1, m_rd2}) begin
                n_fail++;
                $display("FAIL rand_resp[%0d]: got %h want %h", cyc, {bus.rsp_valid, bus.rd1, bus.rd2},
                         {m_valid, m_rd1, m_rd2});
            end
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'h55AA;
        tick();
        bus.we = 1'b0;
        bus.req_valid = 1'b1; bus.ra1 = 5'd9; bus.ra2 = 5'd9; bus.rsp_ready = 1'b0;
        tick();
        n_tests++;
        if ({bus.rsp_valid, bus.rd1, bus.rd2} !== {1'b1, 32'h55AA, 32'h55AA}) begin
            n_fail++;
            $display("FAIL rstmid_stalled: got %h want %h", {bus.rsp_valid, bus.rd1, bus.rd2},
                     {1'b1, 32'h55AA, 32'h55AA});
        end
        #2;
        Clrn = 1'b0;
        #1;
        n_tests++;
        if ({bus.rsp_valid, bus.rd1, bus.rd2} !== {1'b0, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL rstmid_async: got %h want %h", {bus.rsp_valid, bus.rd1, bus.rd2},
                     {1'b0, 32'h0, 32'h0});
        end
        n_tests++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_req_ready: got %b want 1", bus.req_ready);
        end
        idle();
        @(negedge Clk);
        Clrn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.req_valid = 1'b1; bus.ra1 = AW'(i); bus.ra2 = AW'(i + 16);
            tick();
            n_tests++;
            if ({bus.rsp_valid, bus.rd1, bus.rd2} !== {1'b1, 32'h0, 32'h0}) begin
                n_fail++;
                $display("FAIL rstmid_regs[%0d,%0d]: got %h want %h", i, i + 16,
                         {bus.rsp_valid, bus.rd1, bus.rd2}, {1'b1, 32'h0, 32'h0});
            end
        end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_backpressure();
        test_streaming();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
